// File: rtl/fifo_wr_ptr_gray.sv
// -----------------------------------------------------------------------------
// fifo_wr_ptr_gray
//
// Write-side pointer and full-flag stage of an asynchronous FIFO. Keeps the
// binary write pointer (with wrap bit), exports its Gray-coded image to the
// read domain, and synchronises the read domain's Gray pointer back into this
// clock. From those it derives a registered full flag, an occupancy estimate
// and a one-cycle error pulse for writes attempted while full.
//
// Parameters:
//   AW             RAM address width; FIFO depth is 2**AW (AW >= 2).
//
// Ports:
//   clk            write-domain clock, rising edge
//   rst            synchronous active-high reset
//   wr_en          producer write request
//   rd_gptr_async  read pointer in Gray code, asynchronous to clk (AW+1 bits)
//   waddr          RAM write address, low AW bits of the binary pointer
//   wr_accept      combinational RAM write strobe (wr_en & ~full & ~rst)
//   wptr_gray      registered Gray write pointer for the read domain
//   full           registered full flag
//   wr_level       registered occupancy estimate, 0 .. 2**AW
//   wr_err         one-cycle pulse after a write attempt while full
// -----------------------------------------------------------------------------
module fifo_wr_ptr_gray #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW:0]   rd_gptr_async,
   output logic [AW-1:0] waddr,
   output logic          wr_accept,
   output logic [AW:0]   wptr_gray,
   output logic          full,
   output logic [AW:0]   wr_level,
   output logic          wr_err
);

   // Registered state
   logic [AW:0] r_wbin;
   logic [AW:0] r_wgray;
   logic [AW:0] r_rq1;
   logic [AW:0] r_rq2;
   logic        r_full;
   logic [AW:0] r_level;
   logic        r_err;

   // Combinational helpers
   logic        w_accept;
   logic [AW:0] w_wbin_nxt;
   logic [AW:0] w_wgray_nxt;
   logic [AW:0] w_rbin_s;
   logic [AW:0] w_full_gray;

   // Reset gates the strobe so the RAM is never written while state is cleared.
   assign w_accept    = wr_en & ~r_full & ~rst;
   assign w_wbin_nxt  = r_wbin + (AW+1)'(w_accept);
   assign w_wgray_nxt = w_wbin_nxt ^ (w_wbin_nxt >> 1);

   // Gray-to-binary of the synchronised read pointer: each binary bit is the
   // XOR of all Gray bits from the MSB down to that position.
   genvar gi;
   generate
      for (gi = 0; gi <= AW; gi++) begin : g_g2b
         assign w_rbin_s[gi] = ^r_rq2[AW:gi];
      end
   endgenerate

   // In Gray code, "write pointer is exactly one lap ahead of read pointer"
   // means the two MSBs are inverted and the remaining bits match.
   assign w_full_gray = {~r_rq2[AW:AW-1], r_rq2[AW-2:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wbin  <= '0;
         r_wgray <= '0;
         r_rq1   <= '0;
         r_rq2   <= '0;
         r_full  <= 1'b0;
         r_level <= '0;
         r_err   <= 1'b0;
      end else begin
         // Plain two-flop synchroniser; nothing may sit between the stages.
         r_rq1   <= rd_gptr_async;
         r_rq2   <= r_rq1;
         r_wbin  <= w_wbin_nxt;
         r_wgray <= w_wgray_nxt;
         // Using the next pointer makes full/level reflect this cycle's write.
         r_full  <= (w_wgray_nxt == w_full_gray);
         r_level <= w_wbin_nxt - w_rbin_s;
         r_err   <= wr_en & r_full;
      end
   end

   assign waddr     = r_wbin[AW-1:0];
   assign wr_accept = w_accept;
   assign wptr_gray = r_wgray;
   assign full      = r_full;
   assign wr_level  = r_level;
   assign wr_err    = r_err;

endmodule
